pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the RV32I pipelined CPU fetch stage. It replaces the free-running PC counter with:
- a configurable reset vector and post-reset boot delay;
- stall hold and branch/jump redirect;
- misaligned-target trapping and a halt state;
- a saturating fetch counter.

It drives the instruction-memory address and the IF/ID pipeline valid bit.

---
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: boot delay, stall/redirect, misalign trap,
// terminal halt and a saturating count of valid fetches.
module pc_sequencer #(
    parameter int unsigned         ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]   RESET_VEC  = '0,
    parameter int unsigned         BOOT_DELAY = 2,
    parameter int unsigned         CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_target_i,
    input  logic              halt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              fetch_valid_o,
    output logic              misalign_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  fetch_count_o
);

    if (ADDR_W < 3) begin : g_bad_addr_w
        $fatal(1, "pc_sequencer: ADDR_W must be at least 3");
    end
    if (RESET_VEC[1:0] != 2'b00) begin : g_bad_reset_vec
        $fatal(1, "pc_sequencer: RESET_VEC must be 4-byte aligned");
    end

    localparam int unsigned BootLast = (BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0;
    localparam int unsigned BootW    = (BootLast > 0) ? $clog2(BootLast + 1) : 1;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    // A zero boot delay skips BOOT entirely out of reset.
    localparam state_e StReset = (BOOT_DELAY == 0) ? StRun : StBoot;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BootW-1:0]   boot_q, boot_d;
    logic               misalign_q, misalign_d;
    logic               fetch_valid;
    logic [ADDR_W-1:0]  pc_plus4;

    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign fetch_valid = (state_q == StRun) & ~stall_i & ~halt_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        boot_d     = boot_q;
        misalign_d = misalign_q;

        if (fetch_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StBoot: begin
                boot_d = boot_q + BootW'(1);
                if (boot_q == BootW'(BootLast)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (halt_i) begin
                    state_d = StHalt;
                end else if (redirect_i) begin
                    // Misaligned targets trap instead of being masked.
                    if (redirect_target_i[1:0] != 2'b00) begin
                        state_d    = StHalt;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = redirect_target_i;
                    end
                end else if (!stall_i) begin
                    pc_d = pc_plus4;
                end
            end
            StHalt: begin
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StReset;
            pc_q       <= RESET_VEC;
            cnt_q      <= '0;
            boot_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            boot_q     <= boot_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign fetch_valid_o = fetch_valid;
    assign misalign_o    = misalign_q;
    assign state_o       = state_q;
    assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected outputs, a monitor pops
// and compares them on the falling edge (or on demand for the async-reset check).
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       stall_i;
    logic       redirect_i;
    logic [9:0] redirect_target_i;
    logic       halt_i;
    logic [9:0] pc_o;
    logic [9:0] pc_plus4_o;
    logic       fetch_valid_o;
    logic       misalign_o;
    logic [1:0] state_o;
    logic [3:0] fetch_count_o;

    pc_sequencer #(
        .ADDR_W    (10),
        .RESET_VEC (10'h000),
        .BOOT_DELAY(2),
        .CNT_W     (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_target_i(redirect_target_i),
        .halt_i           (halt_i),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o),
        .fetch_valid_o    (fetch_valid_o),
        .misalign_o       (misalign_o),
        .state_o          (state_o),
        .fetch_count_o    (fetch_count_o)
    );

    typedef struct {
        string      name;
        logic [9:0] pc;
        logic [9:0] pc4;
        logic       valid;
        logic       mis;
        logic [1:0] st;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    event mon_ev;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin
        @(negedge clk or mon_ev);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (pc_o !== e.pc || pc_plus4_o !== e.pc4 || fetch_valid_o !== e.valid ||
                misalign_o !== e.mis || state_o !== e.st || fetch_count_o !== e.cnt) begin
                n_fail++;
                $display("FAIL %s: got pc=%h pc4=%h v=%b mis=%b st=%0d cnt=%h, want pc=%h pc4=%h v=%b mis=%b st=%0d cnt=%h",
                         e.name, pc_o, pc_plus4_o, fetch_valid_o, misalign_o, state_o,
                         fetch_count_o, e.pc, e.pc4, e.valid, e.mis, e.st, e.cnt);
            end
        end
    end

    task automatic push(input string nm, input logic [9:0] epc, input logic ev,
                        input logic em, input logic [1:0] est, input logic [3:0] ecnt);
        exp_t e;
        e.name  = nm;
        e.pc    = epc;
        e.pc4   = epc + 10'd4;
        e.valid = ev;
        e.mis   = em;
        e.st    = est;
        e.cnt   = ecnt;
        exp_q.push_back(e);
    endtask

    // Inputs applied here are seen by the following rising edge.
    task automatic step(input string nm, input logic s, input logic r, input logic [9:0] t,
                        input logic h, input logic [9:0] epc, input logic ev, input logic em,
                        input logic [1:0] est, input logic [3:0] ecnt);
        @(posedge clk);
        #1;
        stall_i           = s;
        redirect_i        = r;
        redirect_target_i = t;
        halt_i            = h;
        push(nm, epc, ev, em, est, ecnt);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #4 reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        reset             = 1'b0;
        stall_i           = 1'b0;
        redirect_i        = 1'b0;
        redirect_target_i = '0;
        halt_i            = 1'b0;

        #1 push("reset", 10'h000, 1'b0, 1'b0, 2'd0, 4'd0);
        #11 reset = 1'b1;

        step("boot",  0, 0, 10'h000, 0, 10'h000, 0, 0, 2'd0, 4'd0);
        step("run0",  0, 0, 10'h000, 0, 10'h000, 1, 0, 2'd1, 4'd0);
        for (int i = 1; i <= 3; i++)
            step("run", 0, 0, 10'h000, 0, 10'(4 * i), 1, 0, 2'd1, 4'(i));
        step("stall1", 1, 0, 10'h000, 0, 10'h010, 0, 0, 2'd1, 4'd4);
        step("stall2", 1, 0, 10'h000, 0, 10'h010, 0, 0, 2'd1, 4'd4);
        step("stall3", 1, 0, 10'h000, 0, 10'h010, 0, 0, 2'd1, 4'd4);
        step("redir_stall", 1, 1, 10'h100, 0, 10'h010, 0, 0, 2'd1, 4'd4);
        step("redir_dst", 0, 0, 10'h000, 0, 10'h100, 1, 0, 2'd1, 4'd4);
        step("redir_wrap", 0, 1, 10'h3FC, 0, 10'h104, 1, 0, 2'd1, 4'd5);
        step("pc_top", 0, 0, 10'h000, 0, 10'h3FC, 1, 0, 2'd1, 4'd6);
        for (int i = 0; i <= 41; i++) begin
            c = (7 + i > 15) ? 15 : 7 + i;
            step("wrap_sat", 0, 0, 10'h000, 0, 10'(4 * i), 1, 0, 2'd1, 4'(c));
        end

        // Reset asserted between edges; checked before any further rising edge.
        @(negedge clk);
        #1 reset = 1'b0;
        #1 push("async_reset", 10'h000, 0, 0, 2'd0, 4'd0);
        ->mon_ev;
        #5 reset = 1'b1;

        step("boot2", 0, 0, 10'h000, 0, 10'h000, 0, 0, 2'd0, 4'd0);
        step("run2",  0, 0, 10'h000, 0, 10'h000, 1, 0, 2'd1, 4'd0);
        for (int i = 1; i <= 7; i++)
            step("run2", 0, 0, 10'h000, 0, 10'(4 * i), 1, 0, 2'd1, 4'(i));
        step("mis_req",  0, 1, 10'h102, 0, 10'h020, 1, 0, 2'd1, 4'd8);
        step("mis_trap", 0, 0, 10'h000, 0, 10'h020, 0, 1, 2'd2, 4'd9);
        step("mis_hold", 0, 1, 10'h100, 0, 10'h020, 0, 1, 2'd2, 4'd9);
        step("mis_hold", 0, 0, 10'h000, 0, 10'h020, 0, 1, 2'd2, 4'd9);

        do_reset();
        step("boot3", 0, 0, 10'h000, 0, 10'h000, 0, 0, 2'd0, 4'd0);
        step("run3",  0, 0, 10'h000, 0, 10'h000, 1, 0, 2'd1, 4'd0);
        step("halt_redir", 0, 1, 10'h200, 1, 10'h004, 0, 0, 2'd1, 4'd1);
        step("halted", 0, 0, 10'h000, 0, 10'h004, 0, 0, 2'd2, 4'd1);
        step("halted", 0, 0, 10'h000, 0, 10'h004, 0, 0, 2'd2, 4'd1);
        do_reset();
        step("boot4", 0, 0, 10'h000, 0, 10'h000, 0, 0, 2'd0, 4'd0);

        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
